// File: rtl/core_mem_pkg.sv
// Shared types and helpers for the fetch/data memory port arbiter.
package core_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_MA
  } arb_grant_t;

  localparam int MEM_LATENCY_DEF = 2;

  // Width of a counter that must hold values up to the memory latency.
  function automatic int lat_cnt_w(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

  localparam int LAT_CNT_W_DEF = $clog2(MEM_LATENCY_DEF + 1);

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data stage. The data stage normally wins
// because it belongs to the older instruction; a starved fetch overrides it.
module mem_arb_pick
  import core_mem_pkg::*;
(
  input  logic       if_req,
  input  logic       ma_req,
  input  logic       starved,
  output arb_grant_t grant
);

  // Data stage first unless the fetch has waited out its starvation budget.
  always_comb begin
    grant = GNT_NONE;
    if (ma_req && !(starved && if_req)) begin
      grant = GNT_MA;
    end else if (if_req) begin
      grant = GNT_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data
// stage: serialises requests, sequences the access, returns read data and
// drives per-requester stalls.
//
//  state  | meaning
//  -------+-----------------------------------------------------------------
//  IDLE   | no access in flight; a pending request is granted this cycle
//  ACCESS | mem_addr held for the read latency, or one cycle of mem_we=1
//  RESP   | winner's valid pulses; new requests are not looked at
module mem_port_arbiter
  import core_mem_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              ma_req,
  input  logic              ma_we,
  input  logic [ADDR_W-1:0] ma_addr,
  input  logic [DATA_W-1:0] ma_wdata,
  output logic [DATA_W-1:0] ma_rdata,
  output logic              ma_valid,
  output logic              ma_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT_W  = lat_cnt_w(MEM_LATENCY);
  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(MEM_LATENCY - 1);
  localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(STARVE_LIMIT);

  arb_state_t        state, state_nxt;
  arb_grant_t        pick, grant_q;
  logic [LAT_W-1:0]  lat_cnt;
  logic [SCNT_W-1:0] starve_cnt;
  logic              starved;
  logic              load;
  logic              to_resp;

  assign starved  = (starve_cnt == SCNT_MAX);
  assign if_stall = if_req & ~if_valid;
  assign ma_stall = ma_req & ~ma_valid;

  mem_arb_pick u_pick (
    .if_req  (if_req),
    .ma_req  (ma_req),
    .starved (starved),
    .grant   (pick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; a store leaves ACCESS after its single write cycle, a read
  // once the latency counter has run down.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    to_resp   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick != GNT_NONE) begin
          state_nxt = ACCESS;
          load      = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_we || (lat_cnt == '0)) begin
          state_nxt = RESP;
          to_resp   = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read latency down-counter; terminal count zero marks the capture cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= '0;
    end else if (load) begin
      lat_cnt <= LAT_INIT;
    end else if ((state == ACCESS) && !mem_we && (lat_cnt != '0)) begin
      lat_cnt <= lat_cnt - LAT_W'(1);
    end
  end

  // Starvation count of data grants taken while a fetch waits; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!if_req || (pick == GNT_IF)) begin
        starve_cnt <= '0;
      end else if ((pick == GNT_MA) && !starved) begin
        starve_cnt <= starve_cnt + SCNT_W'(1);
      end
    end
  end

  // Memory-side and requester-side registers; inputs are sampled only at grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q   <= GNT_NONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      if_rdata  <= '0;
      ma_rdata  <= '0;
      if_valid  <= 1'b0;
      ma_valid  <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      ma_valid <= 1'b0;
      if (load) begin
        grant_q  <= pick;
        mem_addr <= (pick == GNT_MA) ? ma_addr : if_addr;
        if ((pick == GNT_MA) && ma_we) begin
          mem_we    <= 1'b1;
          mem_wdata <= ma_wdata;
        end
      end
      if (to_resp) begin
        mem_we   <= 1'b0;
        if_valid <= (grant_q == GNT_IF);
        ma_valid <= (grant_q == GNT_MA);
        if (!mem_we) begin
          if (grant_q == GNT_IF) if_rdata <= mem_rdata;
          if (grant_q == GNT_MA) ma_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
